// File: rtl/mult_share_arb_pkg.sv
// Shared widths and helper functions for the multiplier-sharing arbiter.
package mult_share_arb_pkg;

  localparam int unsigned A_WIDTH_DEF = 8;
  localparam int unsigned B_WIDTH_DEF = 8;
  localparam int unsigned N_REQ_DEF   = 4;
  localparam int unsigned MAX_REQ     = 32;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // Rotating priority encode: first set bit of vld at or after ptr, modulo n (n a power of two).
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] vld,
                                          input int unsigned ptr,
                                          input int unsigned n);
    int unsigned pick;
    int unsigned idx;
    logic        found;
    pick  = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = (ptr + k) & (n - 1);
      if (k < n && !found && vld[idx[4:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mult_share_arb_signed_mult.sv
// Combinational multiplier; tc selects two's-complement or unsigned operands.
module mult_share_arb_signed_mult #(
  parameter int unsigned A_WIDTH       = 8,
  parameter int unsigned B_WIDTH       = 8,
  parameter int unsigned PRODUCT_WIDTH = A_WIDTH + B_WIDTH
) (
  input  logic [A_WIDTH-1:0]       dat_a,
  input  logic [B_WIDTH-1:0]       dat_b,
  input  logic                     tc,
  output logic [PRODUCT_WIDTH-1:0] product
);

  logic [PRODUCT_WIDTH-1:0] a_ext;
  logic [PRODUCT_WIDTH-1:0] b_ext;

  // Sign- or zero-extend to full width; the truncated product is then exact in both modes.
  assign a_ext   = {{(PRODUCT_WIDTH-A_WIDTH){tc & dat_a[A_WIDTH-1]}}, dat_a};
  assign b_ext   = {{(PRODUCT_WIDTH-B_WIDTH){tc & dat_b[B_WIDTH-1]}}, dat_b};
  assign product = a_ext * b_ext;

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin arbiter sharing one multiplier among N_REQ requesters, with a
// single registered result slot under valid/ready backpressure.
module mult_share_arb
  import mult_share_arb_pkg::*;
#(
  parameter int unsigned A_WIDTH       = A_WIDTH_DEF,
  parameter int unsigned B_WIDTH       = B_WIDTH_DEF,
  parameter int unsigned N_REQ         = N_REQ_DEF,
  parameter int unsigned ID_W          = clog2(N_REQ),
  parameter int unsigned PRODUCT_WIDTH = A_WIDTH + B_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_vld,
  output logic [N_REQ-1:0]           req_rdy,
  input  logic [N_REQ*A_WIDTH-1:0]   req_dat_a,
  input  logic [N_REQ*B_WIDTH-1:0]   req_dat_b,
  input  logic [N_REQ-1:0]           req_tc,
  output logic                       out_vld,
  input  logic                       out_rdy,
  output logic [PRODUCT_WIDTH-1:0]   out_product,
  output logic [ID_W-1:0]            out_id
);

  logic [ID_W-1:0]          rr_ptr;
  logic [ID_W-1:0]          gnt_idx;
  logic                     slot_free;
  logic                     accept;
  logic [A_WIDTH-1:0]       sel_a;
  logic [B_WIDTH-1:0]       sel_b;
  logic                     sel_tc;
  logic [PRODUCT_WIDTH-1:0] mult_product;

  assign slot_free = !out_vld || out_rdy;
  assign accept    = (|req_vld) && slot_free && !rst;
  assign gnt_idx   = ID_W'(rr_pick(MAX_REQ'(req_vld), 32'(rr_ptr), N_REQ));

  // Grant decode and operand mux for the winning requester.
  always_comb begin
    req_rdy = '0;
    sel_a   = '0;
    sel_b   = '0;
    sel_tc  = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        sel_a      = req_dat_a[i*A_WIDTH +: A_WIDTH];
        sel_b      = req_dat_b[i*B_WIDTH +: B_WIDTH];
        sel_tc     = req_tc[i];
        req_rdy[i] = accept;
      end
    end
  end

  mult_share_arb_signed_mult #(
    .A_WIDTH       (A_WIDTH),
    .B_WIDTH       (B_WIDTH),
    .PRODUCT_WIDTH (PRODUCT_WIDTH)
  ) u_mult (
    .dat_a   (sel_a),
    .dat_b   (sel_b),
    .tc      (sel_tc),
    .product (mult_product)
  );

  // Result slot and round-robin pointer; the pointer only advances on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld     <= 1'b0;
      out_product <= '0;
      out_id      <= '0;
      rr_ptr      <= '0;
    end else if (accept) begin
      out_vld     <= 1'b1;
      out_product <= mult_product;
      out_id      <= gnt_idx;
      rr_ptr      <= gnt_idx + ID_W'(1);
    end else if (out_rdy) begin
      out_vld     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb with a cycle-level reference model.
module tb_mult_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_vld;
  logic [3:0]  req_rdy;
  logic [31:0] req_dat_a;
  logic [31:0] req_dat_b;
  logic [3:0]  req_tc;
  logic        out_vld;
  logic        out_rdy;
  logic [15:0] out_product;
  logic [1:0]  out_id;
  logic [7:0]  op_a [4];
  logic [7:0]  op_b [4];

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit m_vld  = 1'b0;
  int m_prod = 0;
  int m_id   = 0;
  int m_ptr  = 0;

  always #5 clk = ~clk;

  always_comb begin
    req_dat_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
    req_dat_b = {op_b[3], op_b[2], op_b[1], op_b[0]};
  end

  mult_share_arb dut (
    .clk         (clk),
    .rst         (rst),
    .req_vld     (req_vld),
    .req_rdy     (req_rdy),
    .req_dat_a   (req_dat_a),
    .req_dat_b   (req_dat_b),
    .req_tc      (req_tc),
    .out_vld     (out_vld),
    .out_rdy     (out_rdy),
    .out_product (out_product),
    .out_id      (out_id)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int mexp(input int a, input int b, input bit tc);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (tc) begin
      if (a > 127) sa = a - 256;
      if (b > 127) sb = b - 256;
    end
    return (sa * sb) & 32'hFFFF;
  endfunction

  function automatic int winner(input logic [3:0] v, input int ptr);
    for (int k = 0; k < 4; k++) begin
      if (v[(ptr + k) % 4]) return (ptr + k) % 4;
    end
    return -1;
  endfunction

  // Model: what the slot and pointer must hold after each clock edge.
  always @(posedge clk or posedge rst) begin
    int w;
    if (rst) begin
      m_vld = 1'b0; m_prod = 0; m_id = 0; m_ptr = 0;
    end else begin
      w = winner(req_vld, m_ptr);
      if ((!m_vld || out_rdy) && w >= 0) begin
        m_vld  = 1'b1;
        m_prod = mexp(int'(op_a[w]), int'(op_b[w]), req_tc[w]);
        m_id   = w;
        m_ptr  = (w + 1) % 4;
      end else if (out_rdy) begin
        m_vld = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    int w;
    int erdy;
    if (rst) begin
      chk("cmp_rst_rdy", int'(req_rdy), 0);
      chk("cmp_rst_vld", int'(out_vld), 0);
    end else begin
      w    = winner(req_vld, m_ptr);
      erdy = ((!m_vld || out_rdy) && w >= 0) ? (1 << w) : 0;
      chk("cmp_rdy",  int'(req_rdy), erdy);
      chk("cmp_vld",  int'(out_vld), int'(m_vld));
      chk("cmp_prod", int'(out_product), m_prod);
      chk("cmp_id",   int'(out_id), m_id);
    end
  end

  task automatic do_single(input int i, input logic [7:0] a, input logic [7:0] b,
                           input bit tc, input int exp, input string name);
    @(negedge clk); #2;
    op_a[i]   = a;
    op_b[i]   = b;
    req_tc[i] = tc;
    req_vld   = 4'(1 << i);
    #1 chk({name, "_rdy"}, int'(req_rdy), 1 << i);
    @(negedge clk);
    chk({name, "_vld"},  int'(out_vld), 1);
    chk({name, "_prod"}, int'(out_product), exp);
    chk({name, "_id"},   int'(out_id), i);
    #2 req_vld = 4'b0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    out_rdy = 1'b1;
    req_vld = 4'b1111;
    req_tc  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      op_a[i] = 8'(i + 1);
      op_b[i] = 8'h02;
    end

    // Pin the model against hand-computed products.
    chk("model_s1", mexp(8'hFD, 8'h05, 1'b1), 'hFFF1);
    chk("model_s2", mexp(8'h80, 8'h80, 1'b1), 'h4000);
    chk("model_u1", mexp(8'hFF, 8'hFF, 1'b0), 'hFE01);

    // Reset state with all requesters valid
    repeat (2) @(negedge clk);
    chk("rst_vld",  int'(out_vld), 0);
    chk("rst_prod", int'(out_product), 0);
    chk("rst_id",   int'(out_id), 0);
    chk("rst_rdy",  int'(req_rdy), 0);
    #2 rst = 1'b0;
    #1 chk("first_grant", int'(req_rdy), 'b0001);
    @(negedge clk);
    chk("first_id",   int'(out_id), 0);
    chk("first_prod", int'(out_product), 2);
    #2 req_vld = 4'b0000;

    // Single-requester arithmetic
    do_single(2, 8'hFD, 8'h05, 1'b1, 'hFFF1, "s_m3x5");
    do_single(2, 8'h80, 8'h80, 1'b1, 'h4000, "s_min_sq");
    do_single(2, 8'h80, 8'h01, 1'b1, 'hFF80, "s_min_x1");
    do_single(1, 8'hFF, 8'hFF, 1'b0, 'hFE01, "u_max_sq");
    do_single(0, 8'h80, 8'h80, 1'b0, 'h4000, "u_128_sq");
    do_single(0, 8'hFF, 8'h02, 1'b1, 'hFFFE, "s_m1x2");
    do_single(3, 8'h07, 8'h09, 1'b0, 'h003F, "u_7x9");

    // Round robin with all valid (pointer now at 0)
    @(negedge clk); #2;
    for (int i = 0; i < 4; i++) begin
      op_a[i]   = 8'(8'h10 + i);
      op_b[i]   = 8'h03;
      req_tc[i] = 1'b0;
    end
    req_vld = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_all_id",   int'(out_id), k % 4);
      chk("rr_all_prod", int'(out_product), (16 + k % 4) * 3);
    end
    #2 req_vld = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_skip_id", int'(out_id), (k % 2 == 0) ? 1 : 3);
    end

    // Backpressure
    #2 req_vld = 4'b1111;
    @(negedge clk);
    chk("bp_first_id", int'(out_id), 0);
    #2 out_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_vld",  int'(out_vld), 1);
      chk("bp_id",   int'(out_id), 0);
      chk("bp_prod", int'(out_product), 'h30);
      chk("bp_rdy",  int'(req_rdy), 0);
    end
    #2 out_rdy = 1'b1;
    #1 chk("bp_release_rdy", int'(req_rdy), 'b0010);
    @(negedge clk);
    chk("bp_next_vld", int'(out_vld), 1);
    chk("bp_next_id",  int'(out_id), 1);

    // Reset mid-stream while stalled
    #2 out_rdy = 1'b0;
    @(negedge clk);
    chk("mid_pre_vld", int'(out_vld), 1);
    #3 rst = 1'b1;
    #1;
    chk("mid_async_vld", int'(out_vld), 0);
    chk("mid_async_rdy", int'(req_rdy), 0);
    repeat (2) @(negedge clk);
    #2;
    rst     = 1'b0;
    out_rdy = 1'b1;
    #1 chk("mid_restart_rdy", int'(req_rdy), 'b0001);
    @(negedge clk);
    chk("mid_restart_id", int'(out_id), 0);
    #2 req_vld = 4'b0000;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_share_arb.md
# mult_share_arb

Round-robin arbiter and sequencer sharing a single signed/unsigned multiplier among N_REQ requesters. Each requester presents operands and a two's-complement select under a valid/ready handshake. The block grants one request per cycle, multiplies through one shared combinational multiplier and registers the result with the winner's ID into a single output slot with backpressure. It sits between several datapath clients and the one multiplier instance they share.

## Interface
- A_WIDTH, 8: operand A width
- B_WIDTH, 8: operand B width
- N_REQ, 4: number of requesters (power of two, ≥2)
- ID_W, 2: log2(N_REQ)
- PRODUCT_WIDTH, A_WIDTH+B_WIDTH: result width
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_vld  in  N_REQ  per-requester request valid
- req_rdy  out  N_REQ  per-requester accept (one-hot or zero)
- req_dat_a  in  N_REQ*A_WIDTH  flattened operand A; requester i at [i*A_WIDTH +: A_WIDTH]
- req_dat_b  in  N_REQ*B_WIDTH  flattened operand B, same packing
- req_tc  in  N_REQ  per-requester mode: 0 unsigned, 1 signed
- out_vld  out  1  result valid
- out_rdy  in  1  downstream accept
- out_product  out  PRODUCT_WIDTH  registered product
- out_id  out  ID_W  index of the requester that produced out_product

## Operation
- slot_free = !out_vld || out_rdy.
- Grant (combinational): the first i with req_vld[i]=1, searching rr_ptr, rr_ptr+1, … mod N_REQ.
- req_rdy[i] = grant[i] && slot_free. Requesters hold vld, operands and tc stable until rdy; dropping vld before rdy is illegal.
- accept = |req_vld && slot_free. On accept: out_product ← mult(granted a, b, tc); out_id ← grant index; out_vld ← 1; rr_ptr ← grant index + 1 mod N_REQ.
- No accept and out_rdy=1: out_vld ← 0. out_product and out_id hold their last values.
- out_vld=1 and out_rdy=0: out_product and out_id are stable and all req_rdy are 0.
- rr_ptr changes only on accept. An idle requester is skipped without losing its turn order.
- Arithmetic: tc=0 gives the unsigned product. tc=1 gives the two's-complement product, sign-correct at the extremes (-128*-128 = 0x4000 for 8x8). Results are full width with no truncation.

## Timing
- Reset values: out_vld=0, out_product=0, out_id=0, rr_ptr=0. req_rdy is 0 while rst is high.
- Latency: a request accepted in cycle n appears with out_vld=1 in cycle n+1.
- Throughput: one result per cycle while out_rdy=1 and any request is pending.
- Pop and push in the same cycle (out_vld && out_rdy && accept): the slot is replaced without a bubble.
- Reset mid-operation: pending output is dropped, rr_ptr returns to 0, and no handshake completes in the reset cycle.
- Fairness: with all requesters continuously valid, each is granted exactly once per N_REQ accepts.

## Structure
- Shared package/header holds: default widths, the ID_W = clog2(N_REQ) function, and the round-robin mask/priority-encode function.
- One sub-module: the existing signed_mult combinational multiplier (dat_a, dat_b, tc → product), instantiated once and fed by the grant mux.
- Top block contains the round-robin pointer, grant logic, operand mux and output register.

## Test plan
- Reset: assert rst with req_vld=4'b1111. Required: out_vld=0, product=0, out_id=0, req_rdy=0. After release, the first grant goes to requester 0.
- Signed: requester 2 only, tc=1, a=0xFD, b=0x05, out_rdy=1. Required: req_rdy=4'b0100, then next cycle out_vld=1, product=0xFFF1, out_id=2. Repeat with a=0x80, b=0x80 → 0x4000, and a=0x80, b=0x01 → 0xFF80.
- Unsigned: requester 1, tc=0, a=0xFF, b=0xFF. Required: product=0xFE01, out_id=1.
- Round-robin: all four requesters valid continuously, out_rdy=1. Required: out_id sequence 0,1,2,3,0,1 on consecutive cycles. With only 1 and 3 valid, the sequence is 1,3,1,3.
- Backpressure: out_rdy=0 for 3 cycles while all requesters are valid. Required: product and out_id stable and req_rdy=0 throughout. After out_rdy rises, the next grant is rr_ptr's requester in that same cycle, with no bubble.
- Reset mid-stream: assert rst while out_vld=1 and out_rdy=0. Required: out_vld→0 asynchronously and rr_ptr→0. After release, the grant order restarts at 0.
